atm_account_arbiter: RTL and testbench



---
 rtl/atm_account_arbiter.sv | 169 ++++++++++++++++
 tb/tb_atm_account_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter that serialises deposit/withdraw/balance transactions from
// several ATM terminals onto one shared account-balance store.
module atm_account_arbiter #(
    parameter int NUM_TERM = 2,
    parameter int ACCT_W   = 2,
    parameter int AMT_W    = 5,
    parameter int BAL_W    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_TERM-1:0]        req,
    input  logic [3*NUM_TERM-1:0]      op,
    input  logic [AMT_W*NUM_TERM-1:0]  amount,
    input  logic [ACCT_W*NUM_TERM-1:0] acct,
    output logic [NUM_TERM-1:0]        gnt,
    output logic [NUM_TERM-1:0]        done,
    output logic [1:0]                 status,
    output logic [BAL_W-1:0]           bal_out,
    output logic                       busy
);

    localparam int IDX_W    = (NUM_TERM > 1) ? $clog2(NUM_TERM) : 1;
    localparam int NUM_ACCT = 1 << ACCT_W;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_TERM - 1);

    localparam logic [2:0] OP_DEPOSIT  = 3'b001;
    localparam logic [2:0] OP_WITHDRAW = 3'b010;
    localparam logic [2:0] OP_BALANCE  = 3'b011;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_INSUFF = 2'b01;
    localparam logic [1:0] ST_OVFL   = 2'b10;
    localparam logic [1:0] ST_BAD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [IDX_W-1:0]  last;
    logic [IDX_W-1:0]  winner;
    logic [IDX_W-1:0]  pick;
    logic              any_req;

    logic [2:0]        op_l;
    logic [AMT_W-1:0]  amount_l;
    logic [ACCT_W-1:0] acct_l;

    logic [BAL_W-1:0]  store [NUM_ACCT];

    logic [BAL_W-1:0]  bal_rd;
    logic [BAL_W-1:0]  amt_ext;
    logic [BAL_W:0]    sum;
    logic [1:0]        exec_status;
    logic [BAL_W-1:0]  exec_bal;
    logic              exec_we;

    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offset);
        return IDX_W'((int'(base) + offset) % NUM_TERM);
    endfunction

    // Scan starts just after the last winner, so the previous winner has lowest priority.
    always_comb begin
        any_req = 1'b0;
        pick    = last;
        for (int i = 1; i <= NUM_TERM; i++) begin
            if (!any_req && req[rr_idx(last, i)]) begin
                any_req = 1'b1;
                pick    = rr_idx(last, i);
            end
        end
    end

    // NOTE: state and all registers update with non-blocking assignments so every
    // process samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        busy = (state != IDLE);
        if (state == EXEC) gnt[winner]  = 1'b1;
        if (state == RESP) done[winner] = 1'b1;
    end

    // Read-modify-write evaluation of the latched transaction.
    always_comb begin
        bal_rd      = store[acct_l];
        amt_ext     = BAL_W'(amount_l);
        sum         = {1'b0, bal_rd} + {1'b0, amt_ext};
        exec_status = ST_BAD;
        exec_bal    = bal_rd;
        exec_we     = 1'b0;
        case (op_l)
            OP_DEPOSIT: begin
                if (amount_l == '0) begin
                    exec_status = ST_BAD;
                end else if (sum[BAL_W]) begin
                    exec_status = ST_OVFL;
                end else begin
                    exec_status = ST_OK;
                    exec_bal    = sum[BAL_W-1:0];
                    exec_we     = 1'b1;
                end
            end
            OP_WITHDRAW: begin
                if (amount_l == '0) begin
                    exec_status = ST_BAD;
                end else if (amt_ext > bal_rd) begin
                    exec_status = ST_INSUFF;
                end else begin
                    exec_status = ST_OK;
                    exec_bal    = bal_rd - amt_ext;
                    exec_we     = 1'b1;
                end
            end
            OP_BALANCE:  exec_status = ST_OK;
            default:     exec_status = ST_BAD;
        endcase
    end

    // NOTE: the balance store is cleared by reset because the account model requires
    // every balance to start at zero; this rules out a plain RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCT; i++) store[i] <= '0;
            status   <= ST_OK;
            bal_out  <= '0;
            last     <= LAST_RST;
            winner   <= '0;
            op_l     <= '0;
            amount_l <= '0;
            acct_l   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                winner   <= pick;
                op_l     <= op[3*int'(pick) +: 3];
                amount_l <= amount[AMT_W*int'(pick) +: AMT_W];
                acct_l   <= acct[ACCT_W*int'(pick) +: ACCT_W];
            end
            if (state == EXEC) begin
                status  <= exec_status;
                bal_out <= exec_bal;
                if (exec_we) store[acct_l] <= exec_bal;
            end
            if (state == RESP) last <= winner;
        end
    end

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed plus randomized bench for atm_account_arbiter against an integer-level
// account model with a round-robin pointer.
module tb_atm_account_arbiter;

    localparam int NT   = 2;
    localparam int AW   = 2;
    localparam int MW   = 5;
    localparam int BW   = 5;
    localparam int NACC = 1 << AW;
    localparam int BMAX = (1 << BW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NT-1:0]     req;
    logic [3*NT-1:0]   op;
    logic [MW*NT-1:0]  amount;
    logic [AW*NT-1:0]  acct;
    logic [NT-1:0]     gnt;
    logic [NT-1:0]     done;
    logic [1:0]        status;
    logic [BW-1:0]     bal_out;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;
    int m_bal [NACC];
    int m_last;

    atm_account_arbiter #(.NUM_TERM(NT), .ACCT_W(AW), .AMT_W(MW), .BAL_W(BW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .amount(amount), .acct(acct),
        .gnt(gnt), .done(done), .status(status), .bal_out(bal_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_term(input int t, input logic r, input logic [2:0] o, input int a, input int ac);
        req[t]            = r;
        op[3*t +: 3]      = o;
        amount[MW*t +: MW] = MW'(a);
        acct[AW*t +: AW]  = AW'(ac);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) m_bal[i] = 0;
        m_last = NT - 1;
    endtask

    function automatic int rr_pick(input logic [NT-1:0] r);
        for (int i = 1; i <= NT; i++) begin
            if (r[(m_last + i) % NT]) return (m_last + i) % NT;
        end
        return -1;
    endfunction

    // Account rules: 1 deposit, 2 withdraw, 3 balance, anything else rejected.
    task automatic model_exec(input int o, input int a, input int ac, output int st, output int b);
        int cur;
        cur = m_bal[ac];
        st  = 3;
        b   = cur;
        if (o == 1) begin
            if (a == 0)               st = 3;
            else if (cur + a > BMAX)  st = 2;
            else begin st = 0; b = cur + a; m_bal[ac] = b; end
        end else if (o == 2) begin
            if (a == 0)               st = 3;
            else if (a > cur)         st = 1;
            else begin st = 0; b = cur - a; m_bal[ac] = b; end
        end else if (o == 3) begin
            st = 0;
        end
    endtask

    // One full transaction from the IDLE cycle: arbitration, grant, response, back to IDLE.
    task automatic serve(input string tag, input bit drop);
        int w, o, a, ac, est, eb;
        w  = rr_pick(req);
        o  = int'(op[3*w +: 3]);
        a  = int'(amount[MW*w +: MW]);
        ac = int'(acct[AW*w +: AW]);
        @(posedge clk); #1;
        check({tag, ":gnt"}, 32'(gnt), 32'(1 << w));
        check({tag, ":busy_exec"}, 32'(busy), 32'd1);
        check({tag, ":done_exec"}, 32'(done), 32'd0);
        if (drop) req[w] = 1'b0;
        model_exec(o, a, ac, est, eb);
        @(posedge clk); #1;
        check({tag, ":done"}, 32'(done), 32'(1 << w));
        check({tag, ":gnt_resp"}, 32'(gnt), 32'd0);
        check({tag, ":status"}, 32'(status), 32'(est));
        check({tag, ":bal_out"}, 32'(bal_out), 32'(eb));
        m_last = w;
        @(posedge clk); #1;
        check({tag, ":busy_idle"}, 32'(busy), 32'd0);
        check({tag, ":done_idle"}, 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst:gnt", 32'(gnt), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:status", 32'(status), 32'd0);
        check("rst:bal_out", 32'(bal_out), 32'd0);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        op     = '0;
        amount = '0;
        acct   = '0;
        model_reset();
        do_reset();

        // Basic deposit, withdraw to zero, then insufficient funds.
        set_term(0, 1, 3'b001, 10, 1); serve("dep10", 1);
        set_term(0, 1, 3'b010, 10, 1); serve("wd10", 1);
        set_term(0, 1, 3'b010, 1, 1);  serve("wd1_insuff", 1);

        // Overflow boundary and rejected requests on account 2.
        set_term(0, 1, 3'b001, 30, 2); serve("dep30", 1);
        set_term(0, 1, 3'b001, 2, 2);  serve("dep2_ovfl", 1);
        set_term(0, 1, 3'b001, 1, 2);  serve("dep1_max", 1);
        set_term(0, 1, 3'b001, 0, 2);  serve("dep0_bad", 1);
        set_term(0, 1, 3'b111, 4, 2);  serve("op7_bad", 1);
        set_term(0, 1, 3'b000, 4, 2);  serve("op0_bad", 1);
        set_term(0, 1, 3'b010, 0, 2);  serve("wd0_bad", 1);

        // Same account from both terminals at once; T1 goes first so T0 then has priority.
        set_term(1, 1, 3'b011, 0, 3);  serve("t1_bal", 1);
        set_term(0, 1, 3'b001, 5, 3);
        set_term(1, 1, 3'b010, 5, 3);
        serve("sim_first", 1);
        serve("sim_second", 1);
        set_term(0, 1, 3'b011, 17, 3); serve("bal_ign_amt", 1);

        // Both requesting continuously from reset: alternate 0,1,0,1, then T0 alone.
        set_term(0, 1, 3'b001, 1, 0);
        set_term(1, 1, 3'b011, 0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) serve("alt", 0);
        req[1] = 1'b0;
        for (int i = 0; i < 3; i++) serve("t0_only", 0);
        req = '0;
        @(posedge clk); #1;
        check("quiet:gnt", 32'(gnt), 32'd0);

        // Randomized traffic; pending requesters keep their fields until granted.
        for (int it = 0; it < 80; it++) begin
            for (int t = 0; t < NT; t++) begin
                if (!req[t] && $urandom_range(0, 2) == 0) begin
                    logic [2:0] o;
                    int a;
                    if ($urandom_range(0, 4) != 0) o = 3'($urandom_range(1, 3));
                    else                           o = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 1) == 0) a = int'($urandom_range(0, 8));
                    else                           a = int'($urandom_range(0, BMAX));
                    set_term(t, 1, o, a, int'($urandom_range(0, NACC - 1)));
                end
            end
            if (req == '0) begin
                @(posedge clk); #1;
                check("rand:idle_gnt", 32'(gnt), 32'd0);
                check("rand:idle_busy", 32'(busy), 32'd0);
            end else begin
                serve("rand", 1);
            end
        end
        req = '0;

        // Reset during EXEC discards the deposit and suppresses done.
        set_term(0, 1, 3'b001, 9, 3);
        @(posedge clk); #1;
        check("rstx:gnt", 32'(gnt), 32'd1);
        rst    = 1'b1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        check("rstx:done", 32'(done), 32'd0);
        check("rstx:gnt_after", 32'(gnt), 32'd0);
        check("rstx:busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_reset();
        set_term(0, 1, 3'b011, 0, 3);  serve("rstx_bal", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
